// File: rtl/uart_pkg.sv
// uart_pkg: encodings and helpers shared by the UART receiver and transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a; keeping FSM encodings here keeps rx/tx debug views consistent.
package uart_pkg;

  // Payload width of one UART character.
  localparam int DATA_BITS = 8;

  // FSM encodings (3-bit). S_PARITY is only reachable when parity is built in.
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_START   = 3'd1;
  localparam logic [2:0] S_DATA    = 3'd2;
  localparam logic [2:0] S_STOP    = 3'd3;
  localparam logic [2:0] S_CLEANUP = 3'd4;
  localparam logic [2:0] S_PARITY  = 3'd5;

  // Counter value at which a bit is half-way through, used to validate a start bit.
  function automatic int mid_bit_count(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

  // Even parity: the parity bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for one asynchronous input, programmable reset value.
// Latency: 2 clocks from pin to o_sync.
// Backpressure: none; free-running sampler.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // Two-stage capture; reset value chosen by the user so reset cannot look like line activity.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver, mid-bit sampling, start-glitch rejection, framing check.
// Latency: stop bit sampled (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 clocks after the synced line
//          first reads low (+2 clocks pin-to-sync); o_rx_dv one clock later. Optional even parity: UART_RX_PARITY_EN.
// Backpressure: none; the line cannot be stalled, so each byte is offered for exactly one cycle.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_rx_serial,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_byte,
  output logic                 o_rx_active,
  output logic                 o_rx_frame_err,
  output logic                 o_rx_parity_err
);

  // Bit-period counter width is derived from the period and is never overridden.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LP_MID  = CNT_W'(mid_bit_count(CLKS_PER_BIT));
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LP_LAST_BIT = 3'(DATA_BITS - 1);

  logic                 w_rx_s;
  logic [2:0]           r_state;
  logic [2:0]           w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_cnt_clr;
  logic                 w_mid;
  logic                 w_last;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_byte;
  logic                 r_dv;
  logic                 r_frame_err;
  logic                 r_active;
  logic                 w_data_smp;
  logic                 w_stop_smp;

  // Line idles high, so the synchronizer resets to 1 and reset never fakes a start bit.
  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_rx_serial),
    .o_sync  (w_rx_s)
  );

  assign w_mid      = (r_cnt == LP_MID);
  assign w_last     = (r_cnt == LP_LAST);
  assign w_data_smp = (r_state == S_DATA) && w_last;
  assign w_stop_smp = (r_state == S_STOP) && w_last;

  // Next-state and counter-clear decode; the counter otherwise advances every clock.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_clr = 1'b1;
        if (!w_rx_s) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        // Re-check the line half a bit later; a high line means the edge was noise.
        if (w_mid) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_cnt_clr = 1'b1;
          if (r_bit_idx == LP_LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_last) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_last) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_CLEANUP;
        end
      end
      S_CLEANUP: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_clr   = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and bit-period counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Bit index and shift register: each data bit lands in its own position, LSB first.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else if (r_state != S_DATA) begin
      r_bit_idx <= '0;
    end else if (w_data_smp) begin
      r_shift[r_bit_idx] <= w_rx_s;
      r_bit_idx          <= (r_bit_idx == LP_LAST_BIT) ? 3'd0 : r_bit_idx + 3'd1;
    end
  end

  // Stop-bit verdict: good stop publishes the byte, bad stop keeps the old byte and flags it.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_byte      <= '0;
      r_dv        <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_dv        <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_stop_smp) begin
        if (w_rx_s) begin
          r_byte <= r_shift;
          r_dv   <= 1'b1;
        end else begin
          r_frame_err <= 1'b1;
        end
      end
    end
  end

  // Busy flag tracks the registered state: high from START through CLEANUP.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_active <= 1'b0;
    end else begin
      r_active <= (w_state_nxt != S_IDLE);
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bit;
  logic r_parity_err;

  // Capture the parity bit, then judge it alongside the stop-bit verdict so both strobes coincide.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_par_bit    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= 1'b0;
      if ((r_state == S_PARITY) && w_last) begin
        r_par_bit <= w_rx_s;
      end
      if (w_stop_smp) begin
        r_parity_err <= (even_parity(r_shift) != r_par_bit);
      end
    end
  end

  assign o_rx_parity_err = r_parity_err;
`else
  assign o_rx_parity_err = 1'b0;
`endif

  assign o_rx_dv        = r_dv;
  assign o_rx_byte      = r_byte;
  assign o_rx_active    = r_active;
  assign o_rx_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames checked against a frame-level model of the receiver.
// Latency: strobes are collected whenever they appear and compared per test.
// Backpressure: none; the bench drives the serial line open-loop.
module tb_uart_rx;

  localparam int CPB = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       dv;
  logic [7:0] rx_byte;
  logic       active;
  logic       ferr;
  logic       perr;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clock         (clk),
    .i_reset         (rst),
    .i_rx_serial     (rx),
    .o_rx_dv         (dv),
    .o_rx_byte       (rx_byte),
    .o_rx_active     (active),
    .o_rx_frame_err  (ferr),
    .o_rx_parity_err (perr)
  );

  typedef struct packed {
    logic       dv;
    logic       ferr;
    logic       perr;
    logic [7:0] b;
  } ev_t;

  int   checks = 0;
  int   errors = 0;
  int   both_high = 0;
  ev_t  obs[$];
  ev_t  exp_q[$];
  logic [7:0] last_good;

  // Record every strobe cycle together with the byte output seen at that moment.
  always @(negedge clk) begin
    if (!rst) begin
      if (dv && ferr) both_high++;
      if (dv || ferr || perr) obs.push_back('{dv: dv, ferr: ferr, perr: perr, b: rx_byte});
    end
  end

  // Frame-level expectation: good stop delivers the byte, bad stop flags and keeps the old one.
  function automatic ev_t predict(input logic [7:0] d, input logic stop, input logic flip,
                                  input logic [7:0] prev);
    ev_t e;
    e.dv   = stop;
    e.ferr = !stop;
    e.perr = PARITY_ON ? flip : 1'b0;
    e.b    = stop ? d : prev;
    return e;
  endfunction

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PARITY_ON) send_bit((^d) ^ flip);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (dv !== 1'b0)       begin errors++; $display("FAIL reset_dv got %b want 0", dv); end
    checks++; if (ferr !== 1'b0)     begin errors++; $display("FAIL reset_ferr got %b want 0", ferr); end
    checks++; if (perr !== 1'b0)     begin errors++; $display("FAIL reset_perr got %b want 0", perr); end
    checks++; if (active !== 1'b0)   begin errors++; $display("FAIL reset_active got %b want 0", active); end
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", rx_byte); end
    @(posedge clk); #1;
    rst = 1'b0;
    last_good = 8'h00;
    idle(2 * CPB);
  endtask

  task automatic test_single();
    obs.delete();
    fork
      send_frame(8'hA5, 1'b1, 1'b0);
      begin
        repeat (5 * CPB) @(negedge clk);
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL single_active_mid got %b want 1", active); end
      end
    join
    idle(2 * CPB);
    @(negedge clk);
    checks++; if (active !== 1'b0) begin errors++; $display("FAIL single_active_after got %b want 0", active); end
    checks++; if (obs.size() !== 1) begin errors++; $display("FAIL single_count got %0d want 1", obs.size()); end
    if (obs.size() >= 1) begin
      checks++;
      if (obs[0] !== predict(8'hA5, 1'b1, 1'b0, last_good)) begin
        errors++; $display("FAIL single_event got %b want %b", obs[0], predict(8'hA5, 1'b1, 1'b0, last_good));
      end
    end
    checks++; if (rx_byte !== 8'hA5) begin errors++; $display("FAIL single_hold got %h want a5", rx_byte); end
    last_good = 8'hA5;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d[3];
    d[0] = 8'h00; d[1] = 8'hFF; d[2] = 8'h3C;
    obs.delete();
    for (int i = 0; i < 3; i++) send_frame(d[i], 1'b1, 1'b0);
    idle(2 * CPB);
    checks++; if (obs.size() !== 3) begin errors++; $display("FAIL b2b_count got %0d want 3", obs.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < obs.size()) begin
        checks++;
        if (obs[i] !== predict(d[i], 1'b1, 1'b0, 8'h00)) begin
          errors++; $display("FAIL b2b_event%0d got %b want %b", i, obs[i], predict(d[i], 1'b1, 1'b0, 8'h00));
        end
      end
    end
    last_good = 8'h3C;
  endtask

  task automatic test_glitch();
    bit saw_high = 0;
    bit fell = 0;
    obs.delete();
    rx = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx = 1'b1;
    for (int k = 0; k < CPB + 2 && !fell; k++) begin
      @(negedge clk);
      if (active) saw_high = 1;
      else if (saw_high) fell = 1;
    end
    checks++; if (saw_high !== 1'b1) begin errors++; $display("FAIL glitch_start got %b want 1", saw_high); end
    checks++; if (fell !== 1'b1) begin errors++; $display("FAIL glitch_active_drop got %b want 1 (timeout)", fell); end
    idle(3 * CPB);
    checks++; if (obs.size() !== 0) begin errors++; $display("FAIL glitch_strobes got %0d want 0", obs.size()); end
    checks++; if (rx_byte !== last_good) begin errors++; $display("FAIL glitch_byte got %h want %h", rx_byte, last_good); end
  endtask

  task automatic test_frame_err();
    ev_t e0;
    ev_t e1;
    obs.delete();
    e0 = predict(8'h55, 1'b0, 1'b0, last_good);
    send_frame(8'h55, 1'b0, 1'b0);
    idle(CPB);
    @(negedge clk);
    checks++; if (rx_byte !== last_good) begin errors++; $display("FAIL ferr_hold got %h want %h", rx_byte, last_good); end
    e1 = predict(8'h12, 1'b1, 1'b0, last_good);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(2 * CPB);
    checks++; if (obs.size() !== 2) begin errors++; $display("FAIL ferr_count got %0d want 2", obs.size()); end
    if (obs.size() >= 2) begin
      checks++; if (obs[0] !== e0) begin errors++; $display("FAIL ferr_event got %b want %b", obs[0], e0); end
      checks++; if (obs[1] !== e1) begin errors++; $display("FAIL ferr_next got %b want %b", obs[1], e1); end
    end
    last_good = 8'h12;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d = 8'hC3;
    obs.delete();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (CPB / 2) @(posedge clk);
    #1;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (active !== 1'b0)   begin errors++; $display("FAIL rstmid_active got %b want 0", active); end
    checks++; if (rx_byte !== 8'h00) begin errors++; $display("FAIL rstmid_byte got %h want 00", rx_byte); end
    checks++; if ({dv, ferr, perr} !== 3'b000) begin errors++; $display("FAIL rstmid_strobes got %b want 000", {dv, ferr, perr}); end
    @(posedge clk); #1;
    rst = 1'b0;
    last_good = 8'h00;
    idle(3 * CPB);
    checks++; if (obs.size() !== 0) begin errors++; $display("FAIL rstmid_nostrobe got %0d want 0", obs.size()); end
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(2 * CPB);
    checks++; if (obs.size() !== 1) begin errors++; $display("FAIL rstmid_next_count got %0d want 1", obs.size()); end
    if (obs.size() >= 1) begin
      checks++;
      if (obs[0] !== predict(8'h7E, 1'b1, 1'b0, 8'h00)) begin
        errors++; $display("FAIL rstmid_next got %b want %b", obs[0], predict(8'h7E, 1'b1, 1'b0, 8'h00));
      end
    end
    last_good = 8'h7E;
  endtask

  task automatic test_random();
    obs.delete();
    exp_q.delete();
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic stop;
      logic flip;
      int gap;
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      flip = 1'($urandom_range(0, 1));
      exp_q.push_back(predict(d, stop, flip, last_good));
      if (stop) last_good = d;
      send_frame(d, stop, flip);
      gap = stop ? $urandom_range(0, CPB) : CPB + $urandom_range(0, CPB);
      if (gap > 0) idle(gap);
    end
    idle(3 * CPB);
    checks++; if (obs.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < obs.size()) begin
        checks++;
        if (obs[i] !== exp_q[i]) begin errors++; $display("FAIL rand_event%0d got %b want %b", i, obs[i], exp_q[i]); end
      end
    end
    checks++; if (both_high !== 0) begin errors++; $display("FAIL dv_ferr_overlap got %0d want 0", both_high); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    obs.delete();
    send_frame(8'h81, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b1);
    idle(2 * CPB);
    checks++; if (obs.size() !== 2) begin errors++; $display("FAIL par_count got %0d want 2", obs.size()); end
    if (obs.size() >= 2) begin
      checks++; if (obs[0] !== ev_t'({1'b1, 1'b0, 1'b0, 8'h81})) begin errors++; $display("FAIL par_good got %b want 1_0_0_81", obs[0]); end
      checks++; if (obs[1] !== ev_t'({1'b1, 1'b0, 1'b1, 8'h81})) begin errors++; $display("FAIL par_bad got %b want 1_0_1_81", obs[1]); end
    end
    last_good = 8'h81;
  endtask
`endif

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    last_good = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_mid();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so a stuck run still ends with a visible verdict.
  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
